// File: rtl/adc_frame_packer.sv
// ADC frame packer: on request, emits a header word followed by FRAME_LEN samples into a
// DEPTH-word FIFO, flagging the final sample and recording any words dropped on a full FIFO.
module adc_frame_packer #(
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned DEPTH     = 16,
  parameter logic [15:0] HEADER    = 16'hA5A5
) (
  input  logic        clk_i_50Mhz,
  input  logic        rst,
  input  logic [15:0] data_i,
  input  logic        start_i,
  output logic [15:0] m_data_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic        m_last_o,
  output logic        busy_o,
  output logic        overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [15:0] LastIdx  = 16'(FRAME_LEN - 1);
  localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CntOne   = (AW + 1)'(1);
  localparam logic [AW-1:0] PtrOne = AW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StCapture,
    StDrain
  } state_e;

  state_e state_q, state_d;

  logic [15:0]   smp_cnt_q, smp_cnt_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Each entry carries the last-sample flag in bit 16 alongside the 16-bit word.
  logic [16:0] mem_q [DEPTH];

  logic        push;
  logic        push_ok;
  logic        pop;
  logic [16:0] push_word;
  logic        start_frame;

  // Frame sequencing: header, FRAME_LEN samples, then wait for the FIFO to empty.
  always_comb begin
    state_d     = state_q;
    smp_cnt_d   = smp_cnt_q;
    push        = 1'b0;
    push_word   = '0;
    start_frame = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          start_frame = 1'b1;
          smp_cnt_d   = '0;
          state_d     = StHeader;
        end
      end
      StHeader: begin
        push      = 1'b1;
        push_word = {1'b0, HEADER};
        smp_cnt_d = '0;
        state_d   = StCapture;
      end
      StCapture: begin
        // The counter advances whether or not the FIFO accepts the word.
        push      = 1'b1;
        push_word = {(smp_cnt_q == LastIdx), data_i};
        smp_cnt_d = smp_cnt_q + 16'd1;
        if (smp_cnt_q == LastIdx) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (count_q == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO handshake: a full FIFO still takes a push when the head leaves on the same edge.
  always_comb begin
    pop      = (count_q != '0) && m_ready_i;
    push_ok  = push && ((count_q < DepthCnt) || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CntOne;
    end else if (!push_ok && pop) begin
      count_d = count_q - CntOne;
    end
  end

  // Sticky drop flag, cleared only when a new frame is accepted.
  always_comb begin
    ovf_d = ovf_q;
    if (start_frame) begin
      ovf_d = 1'b0;
    end else if (push && !push_ok) begin
      ovf_d = 1'b1;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk_i_50Mhz or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      smp_cnt_q <= '0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      smp_cnt_q <= smp_cnt_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage; contents are qualified by count_q so no reset is needed.
  always_ff @(posedge clk_i_50Mhz) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  // Outputs are forced to zero while the FIFO is empty so reset leaves them clean.
  always_comb begin
    m_valid_o  = (count_q != '0);
    m_data_o   = m_valid_o ? mem_q[rd_ptr_q][15:0] : 16'h0000;
    m_last_o   = m_valid_o && mem_q[rd_ptr_q][16];
    busy_o     = (state_q != StIdle);
    overflow_o = ovf_q;
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Bench for adc_frame_packer: two instances (FRAME_LEN 8 and 32, DEPTH 16) with scoreboard
// queues filled as stimulus is driven and drained as words leave each DUT.
module tb_adc_frame_packer;

  localparam logic [15:0] HDR = 16'hA5A5;

  logic clk;
  logic rst;

  logic [15:0] a_data, a_m_data;
  logic        a_start, a_ready, a_m_valid, a_m_last, a_busy, a_overflow;
  logic [15:0] b_data, b_m_data;
  logic        b_start, b_ready, b_m_valid, b_m_last, b_busy, b_overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int a_rx     = 0;
  int b_rx     = 0;

  logic [16:0] q_a[$];
  logic [16:0] q_b[$];

  logic        a_stall = 1'b0;
  logic [16:0] a_prev  = '0;
  logic        b_stall = 1'b0;
  logic [16:0] b_prev  = '0;
  logic [16:0] a_exp, b_exp;

  adc_frame_packer #(.FRAME_LEN(8), .DEPTH(16), .HEADER(HDR)) u_dut_a (
    .clk_i_50Mhz(clk),
    .rst        (rst),
    .data_i     (a_data),
    .start_i    (a_start),
    .m_data_o   (a_m_data),
    .m_valid_o  (a_m_valid),
    .m_ready_i  (a_ready),
    .m_last_o   (a_m_last),
    .busy_o     (a_busy),
    .overflow_o (a_overflow)
  );

  adc_frame_packer #(.FRAME_LEN(32), .DEPTH(16), .HEADER(HDR)) u_dut_b (
    .clk_i_50Mhz(clk),
    .rst        (rst),
    .data_i     (b_data),
    .start_i    (b_start),
    .m_data_o   (b_m_data),
    .m_valid_o  (b_m_valid),
    .m_ready_i  (b_ready),
    .m_last_o   (b_m_last),
    .busy_o     (b_busy),
    .overflow_o (b_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Output monitors: pop and compare on every transfer, check hold during stalls.
  always @(negedge clk) begin
    if (!rst) begin
      a_stall = 1'b0;
      b_stall = 1'b0;
    end else begin
      if (a_stall) begin
        chk("a_stall_valid", 32'(a_m_valid), 32'd1);
        chk("a_stall_word", 32'({a_m_last, a_m_data}), 32'(a_prev));
      end
      if (a_m_valid && a_ready) begin
        if (q_a.size() == 0) begin
          n_checks++;
          $display("FAIL a_unexpected_word: got %h expected none", {a_m_last, a_m_data});
        end else begin
          a_exp = q_a.pop_front();
          chk("a_word", 32'({a_m_last, a_m_data}), 32'(a_exp));
        end
        a_rx++;
      end
      a_stall = a_m_valid && !a_ready;
      a_prev  = {a_m_last, a_m_data};

      if (b_stall) begin
        chk("b_stall_word", 32'({b_m_last, b_m_data}), 32'(b_prev));
      end
      if (b_m_valid && b_ready) begin
        if (q_b.size() == 0) begin
          n_checks++;
          $display("FAIL b_unexpected_word: got %h expected none", {b_m_last, b_m_data});
        end else begin
          b_exp = q_b.pop_front();
          chk("b_word", 32'({b_m_last, b_m_data}), 32'(b_exp));
        end
        b_rx++;
      end
      b_stall = b_m_valid && !b_ready;
      b_prev  = {b_m_last, b_m_data};
    end
  end

  // One FRAME_LEN=8 frame on DUT A; samples are the data present at edges 2..9 after start.
  task automatic run_a(input logic [15:0] base, input bit toggle, input int exp_words,
                       input bit exp_ovf);
    int rx0;
    int t;
    rx0 = a_rx;
    q_a.push_back({1'b0, HDR});
    for (t = 0; t < 10; t++) begin
      a_start = (t == 0);
      a_data  = base + 16'(t);
      a_ready = toggle ? (t % 2 == 0) : 1'b1;
      if (t >= 2) q_a.push_back({(t == 9), 16'(base + 16'(t))});
      cyc();
      if (t == 0) chk("a_busy_rise", 32'(a_busy), 32'd1);
    end
    while (t < 200 && (a_busy || q_a.size() != 0)) begin
      a_ready = toggle ? (t % 2 == 0) : 1'b1;
      a_data  = base + 16'(t);
      cyc();
      t++;
    end
    a_ready = 1'b1;
    chk("a_words", 32'(a_rx - rx0), 32'(exp_words));
    chk("a_overflow", 32'(a_overflow), 32'(exp_ovf));
    chk("a_busy_fall", 32'(a_busy), 32'd0);
    chk("a_valid_idle", 32'(a_m_valid), 32'd0);
  endtask

  typedef struct {
    logic [15:0] base;
    bit          toggle;
    int          exp_words;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int rx0;
    int i;

    vecs[0] = '{base: 16'd100,   toggle: 1'b0, exp_words: 9, exp_ovf: 1'b0};
    vecs[1] = '{base: 16'd500,   toggle: 1'b1, exp_words: 9, exp_ovf: 1'b0};
    vecs[2] = '{base: 16'hFFF8,  toggle: 1'b0, exp_words: 9, exp_ovf: 1'b0};
    vecs[3] = '{base: 16'h1234,  toggle: 1'b1, exp_words: 9, exp_ovf: 1'b0};

    rst = 1'b0;
    a_data = '0; a_start = 1'b0; a_ready = 1'b1;
    b_data = '0; b_start = 1'b0; b_ready = 1'b1;
    #1;
    chk("rst_a_valid", 32'(a_m_valid), 32'd0);
    chk("rst_a_last", 32'(a_m_last), 32'd0);
    chk("rst_a_busy", 32'(a_busy), 32'd0);
    chk("rst_a_ovf", 32'(a_overflow), 32'd0);
    chk("rst_a_data", 32'(a_m_data), 32'd0);
    chk("rst_b_valid", 32'(b_m_valid), 32'd0);
    cyc(); cyc();
    rst = 1'b1;
    cyc(); cyc();
    chk("idle_a_valid", 32'(a_m_valid), 32'd0);
    chk("idle_a_busy", 32'(a_busy), 32'd0);

    // Table of single frames, ready either steady or toggling.
    for (int v = 0; v < 4; v++) begin
      run_a(vecs[v].base, vecs[v].toggle, vecs[v].exp_words, vecs[v].exp_ovf);
    end

    // start_i held through CAPTURE/DRAIN: idle reached at edge 11, next header entry at 12.
    rx0 = a_rx;
    a_ready = 1'b1;
    for (int t = 0; t < 26; t++) begin
      a_start = (t <= 12);
      a_data  = 16'd2000 + 16'(t);
      if (t == 0 || t == 12) q_a.push_back({1'b0, HDR});
      if (t >= 2 && t <= 9) q_a.push_back({(t == 9), 16'(16'd2000 + 16'(t))});
      if (t >= 14 && t <= 21) q_a.push_back({(t == 21), 16'(16'd2000 + 16'(t))});
      cyc();
      if (t == 10) chk("held_busy_drain", 32'(a_busy), 32'd1);
      if (t == 11) chk("held_busy_idle", 32'(a_busy), 32'd0);
      if (t == 12) chk("held_busy_restart", 32'(a_busy), 32'd1);
    end
    for (i = 0; i < 50 && (a_busy || q_a.size() != 0); i++) cyc();
    chk("held_words", 32'(a_rx - rx0), 32'd18);
    chk("held_busy_end", 32'(a_busy), 32'd0);

    // Reset mid-capture with header plus four samples buffered.
    a_ready = 1'b0;
    for (int t = 0; t < 6; t++) begin
      a_start = (t == 0);
      a_data  = 16'd3000 + 16'(t);
      cyc();
    end
    chk("pre_rst_valid", 32'(a_m_valid), 32'd1);
    chk("pre_rst_busy", 32'(a_busy), 32'd1);
    rst = 1'b0;
    #1;
    q_a.delete();
    chk("midrst_valid", 32'(a_m_valid), 32'd0);
    chk("midrst_busy", 32'(a_busy), 32'd0);
    chk("midrst_data", 32'(a_m_data), 32'd0);
    chk("midrst_last", 32'(a_m_last), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    a_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      cyc();
      chk("postrst_quiet", 32'({a_m_valid, a_busy}), 32'd0);
    end
    run_a(16'd4000, 1'b0, 9, 1'b0);

    // DUT B overflow: ready low throughout capture, only header + 15 samples fit.
    rx0 = b_rx;
    b_ready = 1'b0;
    for (int t = 0; t < 36; t++) begin
      b_start = (t == 0);
      b_data  = 16'd7000 + 16'(t);
      if (t == 0) q_b.push_back({1'b0, HDR});
      if (t >= 2 && t <= 16) q_b.push_back({1'b0, 16'(16'd7000 + 16'(t))});
      cyc();
      if (t == 16) chk("b_ovf_not_yet", 32'(b_overflow), 32'd0);
      if (t == 17) chk("b_ovf_set", 32'(b_overflow), 32'd1);
    end
    chk("b_full_ovf", 32'(b_overflow), 32'd1);
    chk("b_full_busy", 32'(b_busy), 32'd1);
    chk("b_full_head", 32'({b_m_valid, b_m_last, b_m_data}), 32'({2'b10, HDR}));
    b_ready = 1'b1;
    for (i = 0; i < 60 && (b_busy || q_b.size() != 0); i++) cyc();
    chk("b_ovf_words", 32'(b_rx - rx0), 32'd16);
    chk("b_ovf_busy_end", 32'(b_busy), 32'd0);
    chk("b_ovf_sticky", 32'(b_overflow), 32'd1);

    // DUT B full FIFO with a pop on the push edge: nothing dropped, last flag intact.
    rx0 = b_rx;
    for (int t = 0; t < 34; t++) begin
      b_start = (t == 0);
      b_data  = 16'd9000 + 16'(t);
      b_ready = (t >= 17);
      if (t == 0) q_b.push_back({1'b0, HDR});
      if (t >= 2) q_b.push_back({(t == 33), 16'(16'd9000 + 16'(t))});
      cyc();
      if (t == 0) chk("b_ovf_cleared", 32'(b_overflow), 32'd0);
      if (t == 17) chk("b_full_accept_ovf", 32'(b_overflow), 32'd0);
    end
    for (i = 0; i < 60 && (b_busy || q_b.size() != 0); i++) cyc();
    chk("b_full_words", 32'(b_rx - rx0), 32'd33);
    chk("b_full_ovf_end", 32'(b_overflow), 32'd0);
    chk("b_full_busy_end", 32'(b_busy), 32'd0);

    chk("a_queue_empty", 32'(q_a.size()), 32'd0);
    chk("b_queue_empty", 32'(q_b.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: got no finish expected finish within 1ms");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adc_frame_packer.md
ADC_FRAME_PACKER -- requirements
Module: adc_frame_packer

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 256, meaning samples captured per frame (range 1..65535).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning FIFO depth in 16-bit words (power of two, >=4).
REQ-003 The block SHALL have parameter HEADER, default 16'hA5A5, meaning the frame-start marker word.
REQ-004 The block SHALL have port clk_i_50Mhz  input  1  the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port data_i  input  16  sample stream from the upstream generator, new value every cycle.
REQ-007 The block SHALL have port start_i  input  1  frame request, level-sampled each cycle.
REQ-008 The block SHALL have port m_data_o  output  16  FIFO head word.
REQ-009 The block SHALL have port m_valid_o  output  1  m_data_o holds a valid word.
REQ-010 The block SHALL have port m_ready_i  input  1  downstream accepts the word.
REQ-011 The block SHALL have port m_last_o  output  1  the head word is the final sample of a frame.
REQ-012 The block SHALL have port busy_o  output  1  state is not IDLE.
REQ-013 The block SHALL have port overflow_o  output  1  sticky: at least one word of the current frame was dropped.

Function
REQ-014 The FSM SHALL have states IDLE, HEADER, CAPTURE, DRAIN; busy_o = (state != IDLE).
REQ-015 In IDLE, start_i=1 at an edge SHALL move to HEADER and clear overflow_o; start_i SHALL be ignored in all other states.
REQ-016 HEADER SHALL last exactly one cycle: push HEADER with last=0 at the closing edge, then go to CAPTURE.
REQ-017 CAPTURE SHALL push data_i on each of FRAME_LEN consecutive edges; the 16-bit sample counter SHALL reset to 0 on HEADER entry.
REQ-018 The FRAME_LEN-th pushed sample SHALL carry last=1; the same edge SHALL move to DRAIN.
REQ-019 DRAIN SHALL return to IDLE at the first edge where the FIFO is empty.
REQ-020 A word SHALL transfer at an edge where m_valid_o=1 and m_ready_i=1; the FIFO SHALL then advance.
REQ-021 m_valid_o SHALL be 1 if and only if FIFO count > 0; m_data_o/m_last_o SHALL hold stable while m_valid_o=1 and m_ready_i=0.
REQ-022 A word pushed at edge k into an empty FIFO SHALL appear with m_valid_o=1 immediately after edge k (one-cycle input-to-output latency).
REQ-023 A push SHALL be accepted if count < DEPTH, or if count = DEPTH and a pop occurs on the same edge.
REQ-024 A refused push SHALL drop the word (sample counter still advances) and SHALL set overflow_o at that edge.
REQ-025 A dropped last-sample SHALL still end CAPTURE; the frame is then delivered without m_last_o.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; count SHALL never exceed DEPTH nor go below 0.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; count width SHALL be log2(DEPTH)+1 bits.

Reset
REQ-028 rst=0 SHALL asynchronously force state=IDLE, count=0, pointers=0, sample counter=0, overflow_o=0, m_valid_o=0, m_last_o=0, busy_o=0, m_data_o=16'h0000.
REQ-029 Reset asserted mid-frame SHALL discard all buffered words; after release, no output occurs until a new start_i.
REQ-030 FIFO storage contents SHALL need no reset.

Verification
REQ-031 FRAME_LEN=8, DEPTH=16, m_ready_i=1, data_i ramp 100..; start_i pulse -> words A5A5 then 8 consecutive ramp values, last=1 only on the 8th, overflow_o=0, busy_o falls after final transfer.
REQ-032 FRAME_LEN=32, DEPTH=16, m_ready_i=0 throughout -> 16 words buffered (header + 15 samples), overflow_o=1, then ready=1 -> exactly 16 words drained, none with last=1.
REQ-033 FRAME_LEN=8, m_ready_i toggling 1/0 each cycle -> 9 words in order, no duplicates/losses, data stable during stalls.
REQ-034 start_i held high during CAPTURE and DRAIN -> no second header until IDLE reached; held high through IDLE -> new frame begins next edge.
REQ-035 rst pulsed low mid-CAPTURE with 5 words buffered -> m_valid_o=0 immediately, count=0, busy_o=0; next frame's first word is A5A5.
REQ-036 FIFO full with m_ready_i=1 on push edge -> push accepted, count stays DEPTH, overflow_o stays 0.
